// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// opcodes, functs, ALU codes, mux selects and the FSM state type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_e;

    function automatic logic funct_supported(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic logic [3:0] funct_to_alu(input logic [5:0] f);
        logic [3:0] c;
        c = ALU_ADD;
        case (f)
            FN_SUB:  c = ALU_SUB;
            FN_AND:  c = ALU_AND;
            FN_OR:   c = ALU_OR;
            FN_SLT:  c = ALU_SLT;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decoder: maps the FSM's coarse alu_op plus the
// R-type funct field onto the datapath ALU operation code.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [1:0]            alu_op_i,
    input  logic [5:0]            funct_i,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o
);

    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        unique case (alu_op_i)
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_FUNCT: code = funct_to_alu(funct_i);
            default:     code = ALU_ADD;
        endcase
    end

    assign alu_ctrl_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory handshake and retire counter.
// Optional CTRL_TRAP_EN: illegal opcode/funct enters a sticky TRAP state.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  i_or_d,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem2reg,
    output logic                  instr_done,
`ifdef CTRL_TRAP_EN
    output logic                  trap,
`endif
    output logic [CNT_W-1:0]      instr_count
);

`ifdef CTRL_TRAP_EN
    localparam logic TrapEn = 1'b1;
`else
    localparam logic TrapEn = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                  req_c, rd_c, wr_c, iord_c;
    logic                  irw_c, pcw_c, sa_c;
    logic [1:0]            pcs_c, sb_c, alu_op_c;
    logic                  rw_c, rdst_c, m2r_c;
    logic                  retire_c, trap_c, alu_kill_c;
    logic [ALU_CTRL_W-1:0] alu_dec;

    alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_dec (
        .alu_op_i   (alu_op_c),
        .funct_i    (funct),
        .alu_ctrl_o (alu_dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        rd_c       = 1'b0;
        wr_c       = 1'b0;
        iord_c     = 1'b0;
        irw_c      = 1'b0;
        pcw_c      = 1'b0;
        pcs_c      = PCSRC_ALU;
        sa_c       = 1'b0;
        sb_c       = SRCB_REGB;
        alu_op_c   = ALUOP_ADD;
        rw_c       = 1'b0;
        rdst_c     = 1'b0;
        m2r_c      = 1'b0;
        retire_c   = 1'b0;
        trap_c     = 1'b0;
        alu_kill_c = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                rd_c  = 1'b1;
                sb_c  = SRCB_FOUR;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                sb_c = SRCB_IMM_SH2;
                unique case (opcode)
                    OP_RTYPE: begin
                        if (TrapEn && !funct_supported(funct))
                            state_d = S_TRAP;
                        else
                            state_d = S_R_EXEC;
                    end
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    default: begin
                        // Unknown opcode: trap, or retire as a NOP
                        if (TrapEn) begin
                            state_d = S_TRAP;
                        end else begin
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEM_ADDR: begin
                sa_c    = 1'b1;
                sb_c    = SRCB_IMM;
                state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                req_c  = 1'b1;
                rd_c   = 1'b1;
                iord_c = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                rw_c     = 1'b1;
                m2r_c    = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                req_c  = 1'b1;
                wr_c   = 1'b1;
                iord_c = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_R_EXEC: begin
                sa_c     = 1'b1;
                sb_c     = SRCB_REGB;
                alu_op_c = ALUOP_FUNCT;
                state_d  = S_R_WB;
            end
            S_R_WB: begin
                rw_c     = 1'b1;
                rdst_c   = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_I_EXEC: begin
                sa_c    = 1'b1;
                sb_c    = SRCB_IMM;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                rw_c     = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                sa_c     = 1'b1;
                sb_c     = SRCB_REGB;
                alu_op_c = ALUOP_SUB;
                pcs_c    = PCSRC_ALUOUT;
                pcw_c    = zero;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcs_c    = PCSRC_JUMP;
                pcw_c    = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                trap_c     = 1'b1;
                alu_kill_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign cnt_d = retire_c ? cnt_q + 1'b1 : cnt_q;

    // Reset forces every output low combinationally
    assign mem_req     = reset & req_c;
    assign mem_read    = reset & rd_c;
    assign mem_write   = reset & wr_c;
    assign i_or_d      = reset & iord_c;
    assign ir_write    = reset & irw_c;
    assign pc_write    = reset & pcw_c;
    assign pc_src      = reset ? pcs_c : 2'b00;
    assign alu_src_a   = reset & sa_c;
    assign alu_src_b   = reset ? sb_c : 2'b00;
    assign alu_ctrl    = (reset && !alu_kill_c) ? alu_dec : '0;
    assign reg_write   = reset & rw_c;
    assign reg_dst     = reset & rdst_c;
    assign mem2reg     = reset & m2r_c;
    assign instr_done  = reset & retire_c;
    assign instr_count = reset ? cnt_q : '0;
`ifdef CTRL_TRAP_EN
    assign trap        = reset & trap_c;
`else
    logic unused_trap;
    assign unused_trap = trap_c;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random programs
// against a per-instruction step-plan model. Honours CTRL_TRAP_EN.
module tb_multicycle_ctrl;

    localparam int CW = 4;

`ifdef CTRL_TRAP_EN
    localparam bit TRAP_B = 1'b1;
`else
    localparam bit TRAP_B = 1'b0;
`endif

    typedef struct packed {
        logic       trap;
        logic       req;
        logic       rd;
        logic       wr;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       sa;
        logic [1:0] sb;
        logic [3:0] alu;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       done;
    } ov_t;

    typedef struct packed {
        logic mem;
        logic brz;
        logic care;
        ov_t  o;
    } step_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_read, mem_write, i_or_d;
    logic          ir_write, pc_write, alu_src_a;
    logic [1:0]    pc_src, alu_src_b;
    logic [3:0]    alu_ctrl;
    logic          reg_write, reg_dst, mem2reg, instr_done;
    logic [CW-1:0] instr_count;
    logic          trap_w;

    multicycle_ctrl #(
        .CNT_W      (CW),
        .ALU_CTRL_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .i_or_d      (i_or_d),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_ctrl    (alu_ctrl),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem2reg     (mem2reg),
        .instr_done  (instr_done),
`ifdef CTRL_TRAP_EN
        .trap        (trap_w),
`endif
        .instr_count (instr_count)
    );

`ifndef CTRL_TRAP_EN
    assign trap_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    int    model_cnt = 0;
    int    force_zero = -1;
    step_t plan[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ov_t cur();
        ov_t o;
        o = {trap_w, mem_req, mem_read, mem_write, i_or_d, ir_write,
             pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl,
             reg_write, reg_dst, mem2reg, instr_done};
        return o;
    endfunction

    function automatic bit known_op(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic logic [3:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic step_t alu_step(input logic [1:0] sb,
                                       input logic [3:0] alu);
        step_t s;
        s = '0;
        s.care = 1'b1;
        s.o.sa = 1'b1;
        s.o.sb = sb;
        s.o.alu = alu;
        return s;
    endfunction

    function automatic void plan_instr(input logic [5:0] op,
                                       input logic [5:0] fn);
        step_t s;
        plan.delete();
        s = '0;
        s.mem = 1'b1; s.care = 1'b1;
        s.o.req = 1'b1; s.o.rd = 1'b1; s.o.sb = 2'b01;
        s.o.alu = 4'b0010; s.o.irw = 1'b1; s.o.pcw = 1'b1;
        plan.push_back(s);
        s = '0;
        s.care = 1'b1; s.o.sb = 2'b11; s.o.alu = 4'b0010;
        s.o.done = !known_op(op);
        plan.push_back(s);
        case (op)
            6'b100011: begin
                plan.push_back(alu_step(2'b10, 4'b0010));
                s = '0;
                s.mem = 1'b1; s.o.req = 1'b1; s.o.rd = 1'b1; s.o.iord = 1'b1;
                plan.push_back(s);
                s = '0;
                s.o.rw = 1'b1; s.o.m2r = 1'b1; s.o.done = 1'b1;
                plan.push_back(s);
            end
            6'b101011: begin
                plan.push_back(alu_step(2'b10, 4'b0010));
                s = '0;
                s.mem = 1'b1; s.o.req = 1'b1; s.o.wr = 1'b1; s.o.iord = 1'b1;
                s.o.done = 1'b1;
                plan.push_back(s);
            end
            6'b000000: begin
                plan.push_back(alu_step(2'b00, ref_alu(fn)));
                s = '0;
                s.o.rw = 1'b1; s.o.rdst = 1'b1; s.o.done = 1'b1;
                plan.push_back(s);
            end
            6'b001000: begin
                plan.push_back(alu_step(2'b10, 4'b0010));
                s = '0;
                s.o.rw = 1'b1; s.o.done = 1'b1;
                plan.push_back(s);
            end
            6'b000100: begin
                s = alu_step(2'b00, 4'b0110);
                s.brz = 1'b1; s.o.pcs = 2'b01; s.o.done = 1'b1;
                plan.push_back(s);
            end
            6'b000010: begin
                s = '0;
                s.o.pcs = 2'b10; s.o.pcw = 1'b1; s.o.done = 1'b1;
                plan.push_back(s);
            end
            default: ;
        endcase
    endfunction

    // One clock of a plan step; returns whether the step completed
    task automatic do_step(input step_t s, input bit rdy, input string tag,
                           output bit adv);
        ov_t e, g;
        mem_ready = rdy;
        zero = (force_zero < 0) ? 1'($urandom_range(0, 1)) : force_zero[0];
        @(negedge clk);
        e = s.o;
        if (s.mem && !rdy) begin
            e.irw = 1'b0; e.pcw = 1'b0; e.done = 1'b0;
        end
        if (s.brz) e.pcw = zero;
        g = cur();
        if (!s.care) begin
            e.alu = 4'b0; g.alu = 4'b0;
        end
        check(tag, {11'b0, g}, {11'b0, e});
        @(posedge clk);
        #1;
        adv = !s.mem || rdy;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fwait, output int cyc);
        bit adv, rdy;
        int waits;
        opcode = op;
        funct = fn;
        cyc = 0;
        plan_instr(op, fn);
        foreach (plan[i]) begin
            waits = 0;
            for (int c = 0; c < 16; c++) begin
                if (fwait >= 0) rdy = (waits >= fwait);
                else rdy = (waits >= 3) || ($urandom_range(0, 3) != 0);
                do_step(plan[i], rdy, "outs", adv);
                cyc++;
                if (adv) break;
                waits++;
            end
        end
        model_cnt = (model_cnt + 1) % (1 << CW);
        check("count", 32'(instr_count), 32'(model_cnt));
    endtask

    int    cyc;
    bit    adv;
    step_t s;
    logic [5:0] rop, rfn;
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] bad[3];

    initial begin
        ops = '{6'b000000, 6'b100011, 6'b101011,
                6'b000100, 6'b000010, 6'b001000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bad = '{6'b111111, 6'b000001, 6'b010101};

        reset = 1'b0;
        opcode = 6'b100011;
        mem_ready = 1'b1;
        @(negedge clk);
        check("rst_outs", {11'b0, cur()}, 32'h0);
        check("rst_cnt", 32'(instr_count), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_instr(6'b100011, 6'h00, 0, cyc);
        check("lat_lw", cyc, 5);
        run_instr(6'b001000, 6'h00, 3, cyc);
        check("lat_addi_w3", cyc, 7);
        run_instr(6'b101011, 6'h00, 2, cyc);
        check("lat_sw_w2", cyc, 8);
        force_zero = 1;
        run_instr(6'b000100, 6'h00, 0, cyc);
        check("lat_beq_z1", cyc, 3);
        force_zero = 0;
        run_instr(6'b000100, 6'h00, 0, cyc);
        check("lat_beq_z0", cyc, 3);
        force_zero = -1;
        run_instr(6'b000000, 6'b100010, 0, cyc);
        check("lat_r_sub", cyc, 4);
        run_instr(6'b000000, 6'b101010, 0, cyc);
        run_instr(6'b000010, 6'h00, 0, cyc);
        check("lat_j", cyc, 3);
        if (!TRAP_B) begin
            run_instr(6'b111111, 6'h00, 0, cyc);
            check("lat_nop", cyc, 2);
            run_instr(6'b000000, 6'b000111, 0, cyc);
        end

        while (model_cnt != (1 << CW) - 1) run_instr(6'b000010, 6'h00, 0, cyc);
        run_instr(6'b000010, 6'h00, 0, cyc);
        check("wrap", 32'(instr_count), 32'h0);

        for (int n = 0; n < 150; n++) begin
            if (!TRAP_B && $urandom_range(0, 9) == 0)
                rop = bad[$urandom_range(0, 2)];
            else
                rop = ops[$urandom_range(0, 5)];
            if (!TRAP_B && $urandom_range(0, 1) == 0)
                rfn = 6'($urandom_range(0, 63));
            else
                rfn = fns[$urandom_range(0, 4)];
            run_instr(rop, rfn, -1, cyc);
        end

        // Abandon a load while it waits in the memory-read phase
        opcode = 6'b100011;
        plan_instr(6'b100011, 6'h00);
        for (int i = 0; i < 3; i++) do_step(plan[i], 1'b1, "mid_pre", adv);
        do_step(plan[3], 1'b0, "mid_rd", adv);
        reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", {11'b0, cur()}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_cnt = 0;
        do_step(plan[0], 1'b0, "post_rst", adv);
        check("post_rst_cnt", 32'(instr_count), 32'h0);
        run_instr(6'b000010, 6'h00, 0, cyc);

        if (TRAP_B) begin
            for (int t = 0; t < 2; t++) begin
                if (t == 0) begin
                    opcode = 6'b111111; funct = 6'h00;
                end else begin
                    opcode = 6'b000000; funct = 6'b000111;
                end
                plan_instr(opcode, funct);
                s = plan[1];
                s.o.done = 1'b0;
                do_step(plan[0], 1'b1, "trap_fetch", adv);
                do_step(s, 1'b1, "trap_dec", adv);
                s = '0;
                s.care = 1'b1;
                s.o.trap = 1'b1;
                for (int k = 0; k < 4; k++) do_step(s, 1'b1, "trap_hold", adv);
                check("trap_cnt", 32'(instr_count), 32'(model_cnt));
                reset = 1'b0;
                @(negedge clk);
                check("trap_rst", {11'b0, cur()}, 32'h0);
                @(posedge clk);
                #1;
                reset = 1'b1;
                model_cnt = 0;
                run_instr(6'b001000, 6'h00, 0, cyc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
